uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART RX path. It detects the start-bit edge and times each bit with an oversampling edge counter. It sequences the data sampler, deserializer, start/parity/stop checkers through the START, DATA, PARITY and STOP phases, and issues a single-cycle `data_valid` for a good frame. It sits between the serial input and the check stages: it produces their enables and consumes their error flags.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_ctrl_if.sv | 35 +++
 rtl/uart_rx_edge_bit_counter.sv | 35 +++
 rtl/uart_rx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive-side frame controller.
package uart_rx_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int PRESCALE_W_DEF = 6;

    localparam int PS_8  = 8;
    localparam int PS_16 = 16;
    localparam int PS_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial line, check-stage results and controller strobes bundled for uart_rx_ctrl.
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) ();
    logic                  rx_in;
    logic                  par_en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
               stp_chk_en, data_valid, frame_err, busy
    );

    modport master (
        output rx_in, par_en, prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
               stp_chk_en, data_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter (0..ps-1, wrapping) and per-frame data bit counter.
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  edge_clr,
    input  logic                  edge_en,
    input  logic                  bit_clr,
    input  logic                  bit_en,
    input  logic [PRESCALE_W-1:0] ps,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  last_edge
);
    assign last_edge = edge_en && (edge_cnt == ps - PRESCALE_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (edge_clr)
                edge_cnt <= '0;
            else if (edge_en)
                edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_W'(1);

            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_en && last_edge)
                bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, bit timing, check-stage strobes and
// single-cycle data_valid / frame_err result pulses.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.slave  bus
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e             state, state_nxt;
    logic [PRESCALE_W-1:0] ps;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  last_edge;
    logic                  dv_nxt, fe_nxt;
    logic                  data_valid_p1, frame_err_p1;
    logic                  deser_en, strt_chk_en, par_chk_en, stp_chk_en;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .edge_clr  (state == IDLE),
        .edge_en   (state != IDLE),
        .bit_clr   (state != DATA),
        .bit_en    (state == DATA),
        .ps        (ps),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    // The prescale is captured only when a frame begins so mid-frame changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ps            <= '0;
            data_valid_p1 <= 1'b0;
            frame_err_p1  <= 1'b0;
        end else begin
            state         <= state_nxt;
            data_valid_p1 <= dv_nxt;
            frame_err_p1  <= fe_nxt;
            if (state == IDLE && !bus.rx_in)
                ps <= bus.prescale;
        end
    end

    always_comb begin
        state_nxt   = state;
        dv_nxt      = 1'b0;
        fe_nxt      = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.rx_in)
                    state_nxt = START;
            end
            START: begin
                if (last_edge) begin
                    strt_chk_en = 1'b1;
                    state_nxt   = bus.strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge) begin
                    deser_en = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_W - 1))
                        state_nxt = bus.par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_chk_en = 1'b1;
                    if (bus.par_err) begin
                        fe_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_chk_en = 1'b1;
                    fe_nxt     = bus.stp_err;
                    dv_nxt     = !bus.stp_err;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.edge_cnt    = edge_cnt;
    assign bus.dat_samp_en = (state != IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.deser_en    = deser_en;
    assign bus.strt_chk_en = strt_chk_en;
    assign bus.par_chk_en  = par_chk_en;
    assign bus.stp_chk_en  = stp_chk_en;
    assign bus.data_valid  = data_valid_p1;
    assign bus.frame_err   = frame_err_p1;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame scenarios compared cycle by cycle against a
// timing model derived from bit-index arithmetic.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int PW = 6;
    localparam int SC_GOOD   = 0;
    localparam int SC_GLITCH = 1;
    localparam int SC_PFAIL  = 2;
    localparam int SC_SFAIL  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();

    uart_rx_ctrl #(.DATA_W(DW), .PRESCALE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [13:0] vec;
    assign vec = {bus.busy, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                  bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err,
                  bus.edge_cnt};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle index of the last oversample edge of the frame.
    function automatic int frame_end(input int ps, input bit pe, input int scen);
        case (scen)
            SC_GLITCH: return ps;
            SC_PFAIL:  return ps * (DW + 2);
            default:   return ps * (pe ? DW + 3 : DW + 2);
        endcase
    endfunction

    function automatic logic [13:0] model(input int k, input int ps, input bit pe, input int scen);
        logic [13:0] v;
        int e, b, w;
        bit last;
        v = '0;
        e = frame_end(ps, pe, scen);
        if (k >= 1 && k <= e) begin
            b    = (k - 1) / ps;
            w    = (k - 1) % ps;
            last = (w == ps - 1);
            v[13]  = 1'b1;
            v[12]  = 1'b1;
            v[11]  = last && b >= 1 && b <= DW;
            v[10]  = last && b == 0;
            v[9]   = last && pe && b == DW + 1;
            v[8]   = last && b == (pe ? DW + 2 : DW + 1);
            v[5:0] = w[5:0];
        end else if (k == e + 1) begin
            v[7] = (scen == SC_GOOD);
            v[6] = (scen == SC_PFAIL) || (scen == SC_SFAIL);
        end
        return v;
    endfunction

    function automatic logic rx_level(input int k, input int ps, input bit pe, input logic [7:0] d);
        int b;
        b = (k - 1) / ps;
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (pe && b == DW + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic idle_cycles(input int n);
        bus.rx_in = 1'b1; bus.strt_glitch = 1'b0; bus.stp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.par_err = 1'($urandom % 2);
            @(negedge clk);
            check("idle", 32'(vec), 32'h0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input int ps, input bit pe, input int scen, input logic [7:0] d,
                             input bit started, input bit chain, input int rst_at, input int chg_at);
        int e, n_des, n_par, n_stp, n_fe, dv_at;
        e = frame_end(ps, pe, scen);
        n_des = 0; n_par = 0; n_stp = 0; n_fe = 0; dv_at = -1;
        bus.par_en = pe;
        if (!started) begin
            bus.prescale = PW'(ps); bus.rx_in = 1'b0;
            bus.strt_glitch = 1'b0; bus.stp_err = 1'b0; bus.par_err = 1'($urandom % 2);
            @(negedge clk);
            check("start_cycle0", 32'(vec), 32'(model(0, ps, pe, scen)));
            @(posedge clk); #1;
        end
        for (int k = 1; k <= e + 1; k++) begin
            if (k == chg_at) bus.prescale = PW'(32);
            if (k == e + 1)           bus.rx_in = !chain;
            else if (scen == SC_GLITCH) bus.rx_in = (k < 3) ? 1'b0 : 1'b1;
            else                        bus.rx_in = rx_level(k, ps, pe, d);
            bus.strt_glitch = (scen == SC_GLITCH) && (k == ps);
            if (scen == SC_PFAIL)                 bus.par_err = 1'b1;
            else if (pe && k == ps * (DW + 2))    bus.par_err = 1'b0;
            else                                  bus.par_err = 1'($urandom % 2);
            bus.stp_err = (scen == SC_SFAIL);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_outputs", 32'(vec), 32'h0);
                check("rst_busy", 32'(bus.busy), 32'h0);
                @(posedge clk); #1;
                bus.rx_in = 1'b1;
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            check($sformatf("cyc%0d_ps%0d_sc%0d", k, ps, scen), 32'(vec), 32'(model(k, ps, pe, scen)));
            n_des += int'(bus.deser_en);
            n_par += int'(bus.par_chk_en);
            n_stp += int'(bus.stp_chk_en);
            n_fe  += int'(bus.frame_err);
            if (bus.data_valid) dv_at = k;
            @(posedge clk); #1;
        end
        check("deser_count", 32'(n_des), (scen == SC_GLITCH) ? 32'd0 : 32'(DW));
        check("par_chk_count", 32'(n_par), (pe && scen != SC_GLITCH) ? 32'd1 : 32'd0);
        check("stp_chk_count", 32'(n_stp), (scen == SC_GOOD || scen == SC_SFAIL) ? 32'd1 : 32'd0);
        check("frame_err_count", 32'(n_fe), (scen == SC_PFAIL || scen == SC_SFAIL) ? 32'd1 : 32'd0);
        check("data_valid_cycle", 32'(dv_at), (scen == SC_GOOD) ? 32'(e + 1) : 32'hFFFF_FFFF);
    endtask

    initial begin
        int ps_tab[3] = '{8, 16, 32};
        int ps, scen;
        bit pe;
        bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.prescale = PW'(8);
        bus.strt_glitch = 1'b0; bus.par_err = 1'b1; bus.stp_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(vec), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(3);

        run_frame(8, 1'b1, SC_GOOD, 8'hA5, 1'b0, 1'b0, 0, 0);
        idle_cycles(2);
        run_frame(16, 1'b0, SC_GOOD, 8'h3C, 1'b0, 1'b0, 0, 0);
        idle_cycles(2);
        run_frame(8, 1'b1, SC_GLITCH, 8'h00, 1'b0, 1'b0, 0, 0);
        idle_cycles(2);
        run_frame(8, 1'b1, SC_PFAIL, 8'h5A, 1'b0, 1'b0, 0, 0);
        idle_cycles(2);
        run_frame(8, 1'b1, SC_SFAIL, 8'($urandom), 1'b0, 1'b1, 0, 0);
        run_frame(8, 1'b1, SC_GOOD, 8'($urandom), 1'b1, 1'b0, 0, 0);
        idle_cycles(2);
        run_frame(8, 1'b1, SC_GOOD, 8'($urandom), 1'b0, 1'b0, 30, 0);
        idle_cycles(4);
        run_frame(8, 1'b1, SC_GOOD, 8'($urandom), 1'b0, 1'b0, 0, 20);
        idle_cycles(2);

        for (int i = 0; i < 8; i++) begin
            ps   = ps_tab[$urandom_range(0, 2)];
            pe   = 1'($urandom % 2);
            scen = $urandom_range(0, 3);
            if (scen == SC_PFAIL && !pe) scen = SC_GOOD;
            run_frame(ps, pe, scen, 8'($urandom), 1'b0, 1'b0, 0, 0);
            idle_cycles($urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
